mole_controller: RTL



---
 rtl/game_pkg.sv | 24 ++
 rtl/event_pulser.sv | 41 ++++
 rtl/mole_controller.sv | 136 +++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared constants, FSM state type and popcount helper for the whack-a-mole game slice.
package game_pkg;

  localparam int NUM_MOLES         = 18;
  localparam int IDX_W             = 5;
  localparam int MOLE_LIFE_DEFAULT = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Number of set bits; the result fits IDX_W because NUM_MOLES < 2**IDX_W.
  function automatic logic [IDX_W-1:0] popcount(input logic [NUM_MOLES-1:0] v);
    logic [IDX_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_MOLES; i++) begin
      n = n + IDX_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/event_pulser.sv
// Saturating pending-event counter that serialises queued events into one-cycle pulses.
module event_pulser #(
  parameter int PEND_W = 5,
  parameter int ADD_W  = 5
) (
  input  logic             CLOCK_50,
  input  logic             rst,
  input  logic [ADD_W-1:0] add_cnt,
  output logic             pulse,
  output logic             drained
);

  localparam int              SUM_W    = PEND_W + 1;
  localparam logic [SUM_W-1:0] PEND_MAX = {1'b0, {PEND_W{1'b1}}};

  logic [PEND_W-1:0] pend_q, pend_d;
  logic              pulse_q, pulse_d;
  logic [SUM_W-1:0]  sum, sat;

  // New events are folded in before the pulse decision so a fresh event pulses next cycle.
  always_comb begin
    sum     = {1'b0, pend_q} + SUM_W'(add_cnt);
    sat     = (sum > PEND_MAX) ? PEND_MAX : sum;
    pulse_d = (sat != '0);
    pend_d  = sat[PEND_W-1:0] - PEND_W'(pulse_d);
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      pend_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse   = pulse_q;
  assign drained = (pend_q == '0);

endmodule

// File: rtl/mole_controller.sv
// Mole spawner/ager/judge producing hit and miss pulses for the score updater.
// Define MOLE_TIMEOUT_MISS_EN to charge a miss for every mole that expires unhit.
module mole_controller #(
  parameter int NUM_MOLES  = game_pkg::NUM_MOLES,
  parameter int MOLE_LIFE  = game_pkg::MOLE_LIFE_DEFAULT,
  parameter int MAX_ACTIVE = 4,
  parameter int PEND_W     = 5
) (
  input  logic                 CLOCK_50,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 spawn_tick,
  input  logic [4:0]           random_idx,
  input  logic [NUM_MOLES-1:0] edge_detect,
  output logic [NUM_MOLES-1:0] mole_leds,
  output logic [4:0]           active_count,
  output logic                 hit_pulse,
  output logic                 miss_pulse
);
  import game_pkg::*;

  localparam int AGE_W = $clog2(MOLE_LIFE + 1);

  state_t               state_q, state_d;
  logic [NUM_MOLES-1:0] mole_leds_q, mole_leds_d;
  logic [AGE_W-1:0]     age_q [NUM_MOLES];
  logic [AGE_W-1:0]     age_d [NUM_MOLES];
  logic [IDX_W-1:0]     active_q, active_d;

  logic [IDX_W-1:0]     fold_idx, spawn_idx;
  logic                 spawn_ok;
  logic [NUM_MOLES-1:0] hit_vec, miss_vec, expire_vec;
  logic [AGE_W-1:0]     age_inc;
  logic                 spawn_here;
  logic [IDX_W-1:0]     hit_cnt, miss_cnt;
  logic                 hit_drained, miss_drained;

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    mole_leds_d = mole_leds_q;
    age_d       = age_q;
    hit_vec     = '0;
    miss_vec    = '0;
    expire_vec  = '0;
    age_inc     = '0;
    spawn_here  = 1'b0;
    hit_cnt     = '0;
    miss_cnt    = '0;

    fold_idx  = random_idx - IDX_W'(NUM_MOLES);
    if (random_idx < IDX_W'(NUM_MOLES)) begin
      spawn_idx = random_idx;
    end else if (fold_idx < IDX_W'(NUM_MOLES)) begin
      spawn_idx = fold_idx;
    end else begin
      spawn_idx = '0;
    end
    spawn_ok = spawn_tick && (active_q != IDX_W'(MAX_ACTIVE)) && !mole_leds_q[spawn_idx];

    unique case (state_q)
      IDLE: begin
        if (enable) state_d = RUN;
      end
      RUN: begin
        if (!enable) begin
          // Moles vanish on game stop without being charged as misses.
          state_d     = DRAIN;
          mole_leds_d = '0;
        end else begin
          for (int j = 0; j < NUM_MOLES; j++) begin
            spawn_here    = spawn_ok && (spawn_idx == IDX_W'(j));
            age_inc       = age_q[j] + AGE_W'(1);
            hit_vec[j]    = edge_detect[j] && mole_leds_q[j];
            miss_vec[j]   = edge_detect[j] && !mole_leds_q[j];
            expire_vec[j] = spawn_tick && mole_leds_q[j] && (age_inc == AGE_W'(MOLE_LIFE));
            mole_leds_d[j] = (mole_leds_q[j] && !hit_vec[j] && !expire_vec[j]) || spawn_here;
            if (spawn_here) begin
              age_d[j] = '0;
            end else if (spawn_tick && mole_leds_q[j]) begin
              age_d[j] = age_inc;
            end
          end
          hit_cnt = popcount(hit_vec);
`ifdef MOLE_TIMEOUT_MISS_EN
          miss_cnt = popcount(miss_vec) + popcount(expire_vec & ~hit_vec);
`else
          miss_cnt = popcount(miss_vec);
`endif
        end
      end
      DRAIN: begin
        if (hit_drained && miss_drained) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    active_d = popcount(mole_leds_d);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state_q     <= IDLE;
      mole_leds_q <= '0;
      active_q    <= '0;
      // NOTE: the age array is a handful of flops, so it is reset outright rather than left as memory.
      for (int j = 0; j < NUM_MOLES; j++) age_q[j] <= '0;
    end else begin
      state_q     <= state_d;
      mole_leds_q <= mole_leds_d;
      active_q    <= active_d;
      age_q       <= age_d;
    end
  end

  event_pulser #(.PEND_W(PEND_W), .ADD_W(IDX_W)) u_hit_pulser (
    .CLOCK_50 (CLOCK_50),
    .rst      (rst),
    .add_cnt  (hit_cnt),
    .pulse    (hit_pulse),
    .drained  (hit_drained)
  );

  event_pulser #(.PEND_W(PEND_W), .ADD_W(IDX_W)) u_miss_pulser (
    .CLOCK_50 (CLOCK_50),
    .rst      (rst),
    .add_cnt  (miss_cnt),
    .pulse    (miss_pulse),
    .drained  (miss_drained)
  );

  assign mole_leds    = mole_leds_q;
  assign active_count = active_q;

endmodule
